dht11_sched: RTL and testbench

//  Measurement scheduler between the debounced key / auto timer and the DHT11 single-wire controller.
//  - Merges manual and periodic read requests.
//  - Enforces the sensor's minimum inter-read gap, including power-up settling.
//  - Issues one start pulse per transaction and supervises it with a timeout.
//  - Latches verified humidity/temperature for the seg display path.

---
 rtl/dht11_pkg.sv | 23 ++
 rtl/dht11_period_tick.sv | 36 +++
 rtl/dht11_sched.sv | 173 +++++++++++++++++
 tb/tb_dht11_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared types for the DHT11 measurement scheduler: FSM encoding and rx_data field layout.
// Used by dht11_sched (optional DHT11_RETRY_EN build) and dht11_period_tick.
package dht11_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // rx_data = {hum_int, hum_dec, temp_int, temp_dec}
  localparam int FIELD_W  = 16;
  localparam int HUM_LSB  = 16;
  localparam int TEMP_LSB = 0;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dht11_period_tick.sv
// Free-running period counter with enable; emits a 1-cycle tick on the last count, then wraps.
// Disabling holds the count at zero so a fresh enable always yields a full period.
module dht11_period_tick
  import dht11_pkg::*;
#(
  parameter int PERIOD_CYC = 250_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dht11_sched.sv
// DHT11 read scheduler: merges key/auto requests, enforces the inter-read gap, supervises
// each transaction with a timeout and latches good readings. Define DHT11_RETRY_EN for one silent retry.
module dht11_sched
  import dht11_pkg::*;
#(
  parameter int MIN_GAP_CYC     = 100_000_000,
  parameter int AUTO_PERIOD_CYC = 250_000_000,
  parameter int TIMEOUT_CYC     = 2_500_000
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        key_i,
  input  logic        auto_en_i,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic        chk_ok_i,
  input  logic [31:0] rx_data_i,
  output logic        start_o,
  output logic [15:0] hum_o,
  output logic [15:0] temp_o,
  output logic        data_vld_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  // One counter serves both the gap (GAP) and the timeout (WAIT); sized for the larger.
  localparam int CNT_W = $clog2(max2(MIN_GAP_CYC, TIMEOUT_CYC));
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(MIN_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [FIELD_W-1:0] hum_q, hum_d;
  logic [FIELD_W-1:0] temp_q, temp_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               auto_tick;
  logic               req;
  logic               fail;
`ifdef DHT11_RETRY_EN
  logic               retry_q, retry_d;
`endif

  dht11_period_tick #(
    .PERIOD_CYC(AUTO_PERIOD_CYC)
  ) u_auto_tick (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .en_i  (auto_en_i),
    .tick_o(auto_tick)
  );

  assign req = key_i | auto_tick;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | req;
    hum_d     = hum_q;
    temp_d    = temp_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    fail      = 1'b0;
    start_o   = 1'b0;
`ifdef DHT11_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_q && !busy_i) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Requests seen during the pulse cycle belong to the next transaction.
        start_o = 1'b1;
        pend_d  = req;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_i) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (chk_ok_i) begin
            hum_d  = rx_data_i[HUM_LSB +: FIELD_W];
            temp_d = rx_data_i[TEMP_LSB +: FIELD_W];
            vld_d  = 1'b1;
            err_d  = 1'b0;
`ifdef DHT11_RETRY_EN
            retry_d = 1'b0;
`endif
          end else begin
            fail = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          fail    = 1'b1;
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
`ifdef DHT11_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        pend_d  = 1'b1;
      end else begin
        retry_d = 1'b0;
        err_d   = 1'b1;
        if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
      end
`else
      err_d = 1'b1;
      if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q   <= ST_GAP;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      hum_q     <= '0;
      temp_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef DHT11_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      hum_q     <= hum_d;
      temp_q    <= temp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef DHT11_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign hum_o      = hum_q;
  assign temp_o     = temp_q;
  assign data_vld_o = vld_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_dht11_sched.sv
// Self-checking bench for dht11_sched: timestamp-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours DHT11_RETRY_EN.
module tb_dht11_sched;

  localparam int MIN_GAP = 20;
  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 50;
`ifdef DHT11_RETRY_EN
  localparam int ATT = 2;
`else
  localparam int ATT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key = 1'b0;
  logic        auto_en = 1'b0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        chk_ok = 1'b0;
  logic [31:0] rx = '0;
  logic        start;
  logic [15:0] hum, temp;
  logic        vld, err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dht11_sched #(
    .MIN_GAP_CYC    (MIN_GAP),
    .AUTO_PERIOD_CYC(PERIOD),
    .TIMEOUT_CYC    (TIMEOUT)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .key_i     (key),
    .auto_en_i (auto_en),
    .busy_i    (busy),
    .done_i    (done),
    .chk_ok_i  (chk_ok),
    .rx_data_i (rx),
    .start_o   (start),
    .hum_o     (hum),
    .temp_o    (temp),
    .data_vld_o(vld),
    .err_o     (err),
    .err_cnt_o (err_cnt)
  );

  // Reference model: tracks absolute deadlines (cycle numbers) rather than counters.
  bit          m_on = 0, m_start = 0, m_txn = 0, m_pend = 0, m_vld = 0, m_err = 0, m_retry = 0;
  logic [15:0] m_hum = '0, m_temp = '0;
  int          m_errs = 0, t_free = 0, t_dead = 0, run_len = 0;

  always @(posedge clk) begin
    bit req, fail;
    cyc++;
    req = key || (auto_en && ((run_len % PERIOD) == PERIOD - 1));
    run_len = (rst || !auto_en) ? 0 : run_len + 1;
    m_vld = 0;
    fail  = 0;
    if (rst) begin
      m_on = 1; m_start = 0; m_txn = 0; m_pend = 0; m_err = 0; m_retry = 0;
      m_hum = '0; m_temp = '0; m_errs = 0;
      t_free = cyc + MIN_GAP;
    end else if (m_start) begin
      m_start = 0;
      m_txn   = 1;
      t_dead  = cyc + TIMEOUT;
      m_pend  = req;
    end else if (m_txn) begin
      m_pend = m_pend || req;
      if (done) begin
        m_txn  = 0;
        t_free = cyc + MIN_GAP;
        if (chk_ok) begin
          m_hum = rx[31:16]; m_temp = rx[15:0];
          m_vld = 1; m_err = 0; m_retry = 0;
        end else begin
          fail = 1;
        end
      end else if (cyc == t_dead) begin
        m_txn  = 0;
        t_free = cyc + MIN_GAP;
        fail   = 1;
      end
    end else if (cyc > t_free && m_pend && !busy) begin
      m_start = 1;
    end else begin
      m_pend = m_pend || req;
    end
    if (fail) begin
      if (ATT == 2 && !m_retry) begin
        m_retry = 1;
        m_pend  = 1;
      end else begin
        m_retry = 0;
        m_err   = 1;
        m_errs++;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      cmp("start", start, m_start);
      cmp("hum", hum, m_hum);
      cmp("temp", temp, m_temp);
      cmp("data_vld", vld, m_vld);
      cmp("err", err, m_err);
      cmp("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_key();
    key = 1'b1;
    step();
    key = 1'b0;
  endtask

  task automatic wait_start(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_start: no start within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  // Call in the cycle start is visible: done lands on the second WAIT edge.
  task automatic respond(input bit ok, input logic [31:0] data);
    step();
    done = 1'b1; chk_ok = ok; rx = data;
    step();
    done = 1'b0; chk_ok = 1'b0;
  endtask

  task automatic count_starts(input int len, output int n);
    n = 0;
    repeat (len) begin
      @(negedge clk);
      if (start === 1'b1) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s, s2, s3, e, n, ke;

    // Reset and power-up settle
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    r = cyc;
    @(negedge clk);
    cmp("rst_start", start, 0);
    cmp("rst_hum", hum, 0);
    cmp("rst_err_cnt", err_cnt, 0);
    step(4);
    pulse_key();
    wait_start(40, s);
    cmp("first_start_cycle", s - r, MIN_GAP + 1);

    // Good read
    respond(1'b1, 32'h3700_1A05);
    @(negedge clk);
    cmp("good_vld", vld, 1);
    cmp("good_hum", hum, 16'h3700);
    cmp("good_temp", temp, 16'h1A05);
    cmp("good_err", err, 0);

    // Timeout (retry build: one silent retry first)
    pulse_key();
    wait_start(60, s);
    e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_err: err never rose (cycle %0d)", cyc);
    end else begin
      cmp("timeout_latency", e - s, (TIMEOUT + 1) + (ATT - 1) * (MIN_GAP + TIMEOUT + 2));
    end
    cmp("timeout_err_cnt", err_cnt, 1);
    cmp("timeout_hum_kept", hum, 16'h3700);

    // done coincident with timeout: done wins
    pulse_key();
    wait_start(60, s);
    while (cyc < s + TIMEOUT) step();
    done = 1'b1; chk_ok = 1'b1; rx = 32'h4100_1702;
    step();
    done = 1'b0; chk_ok = 1'b0;
    @(negedge clk);
    cmp("race_vld", vld, 1);
    cmp("race_err", err, 0);
    cmp("race_hum", hum, 16'h4100);

    // Auto requests and key coincident with a tick
    step(30);
    auto_en = 1'b1;
    r = cyc + 1;
    wait_start(150, s);
    cmp("auto_first", s - r, PERIOD);
    respond(1'b1, 32'h2A00_1900);
    wait_start(150, s2);
    cmp("auto_period", s2 - s, PERIOD);
    respond(1'b1, 32'h2B00_1901);
    while (cyc < r + 3 * PERIOD - 2) step();
    pulse_key();
    wait_start(10, s3);
    cmp("coincident_start", s3 - r, 3 * PERIOD);
    respond(1'b1, 32'h2C00_1902);
    count_starts(60, n);
    cmp("coincident_single", n, 0);
    auto_en = 1'b0;

    // Requests during START and WAIT merge into one follow-up
    step(30);
    pulse_key();
    wait_start(40, s);
    key = 1'b1;
    step();
    key = 1'b0;
    step(2);
    pulse_key();
    step();
    pulse_key();
    done = 1'b1; chk_ok = 1'b1; rx = 32'h3300_1600;
    step();
    done = 1'b0; chk_ok = 1'b0;
    ke = cyc;
    wait_start(40, s2);
    cmp("merged_gap", s2 - ke, MIN_GAP + 1);
    respond(1'b1, 32'h3400_1601);
    count_starts(60, n);
    cmp("merged_single", n, 0);

    // busy holds IDLE; done outside WAIT is ignored
    step(30);
    busy = 1'b1;
    done = 1'b1; chk_ok = 1'b1; rx = 32'hFFFF_FFFF;
    step();
    done = 1'b0; chk_ok = 1'b0;
    pulse_key();
    count_starts(40, n);
    cmp("busy_hold", n, 0);
    cmp("stray_done_hum", hum, 16'h3400);
    busy = 1'b0;
    wait_start(5, s);
    respond(1'b1, 32'h3500_1602);

    // Reset mid-transaction
    step(30);
    pulse_key();
    wait_start(40, s);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r = cyc;
    @(negedge clk);
    cmp("midrst_hum", hum, 0);
    cmp("midrst_temp", temp, 0);
    cmp("midrst_err", err, 0);
    cmp("midrst_start", start, 0);
    pulse_key();
    wait_start(40, s);
    cmp("midrst_gap", s - r, MIN_GAP + 1);
    respond(1'b1, 32'h3600_1603);

    // 300 reported failures saturate err_cnt
    for (int k = 0; k < 300; k++) begin
      pulse_key();
      for (int a = 0; a < ATT; a++) begin
        wait_start(40, s);
        respond(1'b0, 32'h0102_0304);
      end
    end
    step(2);
    @(negedge clk);
    cmp("sat_err_cnt", err_cnt, 255);
    cmp("sat_err", err, 1);
    cmp("sat_hum_kept", hum, 16'h3600);

    // A good read clears err but not the count
    pulse_key();
    wait_start(40, s);
    respond(1'b1, 32'h3700_1A05);
    @(negedge clk);
    cmp("recover_err", err, 0);
    cmp("recover_vld", vld, 1);
    cmp("recover_err_cnt", err_cnt, 255);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
